// File: rtl/mod_arbiter.sv
// Two-requester arbiter in front of one shared repeated-subtraction MOD engine.
// Define MOD_ARB_FIXED_PRIORITY_EN to make requester 0 always win; default is round-robin.
module mod_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic             grant1;
  logic             idle;

  assign idle = (state_q == IDLE);

`ifdef MOD_ARB_FIXED_PRIORITY_EN
  assign grant1 = req1_valid && !req0_valid;
`else
  logic last_q;

  // last_q remembers who was served last so contention alternates.
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if (req0_ready) begin
      last_q <= 1'b0;
    end else if (req1_ready) begin
      last_q <= 1'b1;
    end
  end
`endif

  // Readys are gated by reset so both read 0 while reset is held.
  assign req0_ready = reset && idle && req0_valid && !grant1;
  assign req1_ready = reset && idle && grant1;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      result_q <= result_d;
      id_q     <= id_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    div_d    = div_q;
    result_d = result_q;
    id_d     = id_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          rem_d   = req0_a;
          div_d   = req0_b;
          id_d    = 1'b0;
          state_d = CALC;
        end else if (req1_ready) begin
          rem_d   = req1_a;
          div_d   = req1_b;
          id_d    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // With a zero modulus rem_q still holds the untouched dividend.
        if (div_q == '0) begin
          err_d    = 1'b1;
          result_d = rem_q;
          state_d  = DONE;
        end else if (rem_q < div_q) begin
          err_d    = 1'b0;
          result_d = rem_q;
          state_d  = DONE;
        end else begin
          rem_d = rem_q - div_q;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid  = (state_q == DONE);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_mod_arbiter.sv
// Directed, table-driven bench for mod_arbiter with hand-written sequences
// for contention, response back-pressure and mid-operation reset.
module tb_mod_arbiter;

  localparam int WIDTH = 32;

  logic             CLK;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [WIDTH-1:0] rsp_result;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expErr;
    int          expLatency;
  } vec_t;

  vec_t vecs[9];

  mod_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, " rsp_id"}, {31'd0, rsp_id}, 32'd0);
    checkOutput({tag, " rsp_result"}, rsp_result, 32'd0);
    checkOutput({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, " readys"}, {30'd0, req1_ready, req0_ready}, 32'd0);
  endtask

  // Issue one request alone, time the response, check it, then drain it.
  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    if (v.id == 0) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b;
    end
    #1;
    checkOutput({tag, " readys"}, {30'd0, req1_ready, req0_ready}, (v.id == 0) ? 32'd1 : 32'd2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEAD_BEEF; req0_b = 32'd3; req1_a = 32'h1234_5678; req1_b = 32'd0;
    rsp_ready = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 300) begin
      tick();
      lat++;
    end
    checkOutput({tag, " latency"}, lat, v.expLatency);
    checkOutput({tag, " rsp_result"}, rsp_result, v.expResult);
    checkOutput({tag, " rsp_id"}, {31'd0, rsp_id}, v.id);
    checkOutput({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, v.expErr});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, " idle after drain"}, {30'd0, busy, rsp_valid}, 32'd0);
  endtask

  initial begin
    int ids[4];
    int nrsp;
    int cyc;
    int expId;

    vecs[0] = '{0, 32'd10, 32'd4, 32'd2, 1'b0, 3};
    vecs[1] = '{1, 32'd74, 32'd7, 32'd4, 1'b0, 11};
    vecs[2] = '{0, 32'd5, 32'd0, 32'd5, 1'b1, 1};
    vecs[3] = '{1, 32'd3, 32'd9, 32'd3, 1'b0, 1};
    vecs[4] = '{0, 32'd9, 32'd9, 32'd0, 1'b0, 2};
    vecs[5] = '{1, 32'd0, 32'd5, 32'd0, 1'b0, 1};
    vecs[6] = '{0, 32'd100, 32'd1, 32'd0, 1'b0, 101};
    vecs[7] = '{1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 2};
    vecs[8] = '{1, 32'd0, 32'd0, 32'd0, 1'b1, 1};

    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd10; req0_b = 32'd4; req1_a = 32'd74; req1_b = 32'd7;
    rsp_ready = 1'b1;
    #12;
    checkAllZero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Contention: both requesters valid, consumer always ready.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4;
    req1_valid = 1'b1; req1_a = 32'd74; req1_b = 32'd7;
    rsp_ready = 1'b1;
    nrsp = 0;
    cyc = 0;
    while (nrsp < 4 && cyc < 200) begin
      #1;
      if (req0_ready && req1_ready) checkOutput("rr both ready", 32'd1, 32'd0);
      if (rsp_valid) begin
        ids[nrsp] = rsp_id;
        nrsp++;
      end
      tick();
      cyc++;
    end
    checkOutput("rr response count", nrsp, 4);
    for (int i = 0; i < 4; i++) begin
`ifdef MOD_ARB_FIXED_PRIORITY_EN
      expId = 0;
`else
      expId = i % 2;
`endif
      checkOutput($sformatf("rr id%0d", i), (i < nrsp) ? ids[i] : -1, expId);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      if (rsp_valid) rsp_ready = 1'b1;
      tick();
      cyc++;
    end
    rsp_ready = 1'b0;
    checkOutput("rr drained", {31'd0, busy}, 32'd0);

    // Back-pressure: hold DONE for 5 cycles with both requesters pending.
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4;
    tick();
    req0_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("hold%0d rsp", i), {rsp_valid, rsp_id, rsp_err, rsp_result[28:0]}, {3'b100, 29'd2});
      checkOutput($sformatf("hold%0d readys", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("hold release idle", {30'd0, busy, rsp_valid}, 32'd0);

    // Reset in the middle of a 74 mod 7 computation.
    req1_valid = 1'b1; req1_a = 32'd74; req1_b = 32'd7;
    tick();
    req1_valid = 1'b0;
    tick(); tick(); tick();
    checkOutput("midcalc busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkAllZero("midcalc reset");
    tick();
    reset = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid || busy) nrsp++;
      tick();
    end
    checkOutput("no stale response", nrsp, 0);
    applyStimulus(vecs[0], "post reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
